regfile_2r1w: RTL and testbench

Parametrised register file with one write port and two registered read ports. It replaces the fixed 8×16-bit, bit-sliced, purely combinational read select in the decode stage. WIDTH, register count and a hardwired-zero option are generic. Each read port adds a pipeline register with enable/stall, valid tracking and write-to-read bypass, so the decode/execute boundary no longer needs a separate latch.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_read_port.sv | 81 ++++++++
 rtl/regfile_2r1w.sv | 97 +++++++++
 tb/tb_regfile_2r1w.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults and select-width helper for the 2R1W regfile.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int REGFILE_WIDTH = 16;
    localparam int REGFILE_NREGS = 8;

    // $clog2(1) is 0, which would produce a zero-width select bus
    function automatic int regfile_sel_w(input int nregs);
        return (nregs <= 1) ? 1 : $clog2(nregs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_port
// Description : Registered read port with same-edge write bypass, zero-register
//               and out-of-range gating, valid pulse and out-of-range flag.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int   WIDTH    = REGFILE_WIDTH,
    parameter int   NREGS    = REGFILE_NREGS,
    parameter bit   ZERO_REG = 1'b0,
    localparam int  SEL_W    = regfile_sel_w(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREGS*WIDTH-1:0] i_regs,
    input  logic                   i_wr_en,
    input  logic [SEL_W-1:0]       i_wr_sel,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic                   i_rd_en,
    input  logic [SEL_W-1:0]       i_rd_sel,
    output logic [WIDTH-1:0]       o_rd_data,
    output logic                   o_rd_valid,
    output logic                   o_rd_oor
);

    localparam logic [SEL_W:0] c_NREGS = NREGS[SEL_W:0];

    logic             w_oor;
    logic             w_bypass;
    logic [WIDTH-1:0] w_stored;
    logic [WIDTH-1:0] w_sel_val;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_rd_oor;

    assign w_oor    = ({1'b0, i_rd_sel} >= c_NREGS);
    assign w_bypass = i_wr_en && (i_wr_sel == i_rd_sel);

    always_comb begin
        w_stored = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (i_rd_sel == SEL_W'(i)) begin
                w_stored = i_regs[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_sel_val = w_stored;
        if (w_oor) begin
            w_sel_val = '0;
        end else if (ZERO_REG && (i_rd_sel == '0)) begin
            w_sel_val = '0;
        end else if (w_bypass) begin
            w_sel_val = i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_oor   <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                r_rd_data <= w_sel_val;
                r_rd_oor  <= w_oor;
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_rd_oor   = r_rd_oor;

endmodule
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : regfile_2r1w
// Description : Parametrised register file, one write port, two registered
//               read ports with bypass and valid tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int   WIDTH    = REGFILE_WIDTH,
    parameter int   NREGS    = REGFILE_NREGS,
    parameter bit   ZERO_REG = 1'b0,
    localparam int  SEL_W    = regfile_sel_w(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en0,
    input  logic [SEL_W-1:0] rd_sel0,
    input  logic             rd_en1,
    input  logic [SEL_W-1:0] rd_sel1,
    output logic [WIDTH-1:0] rd_data0,
    output logic [WIDTH-1:0] rd_data1,
    output logic             rd_valid0,
    output logic             rd_valid1,
    output logic             rd_oor0,
    output logic             rd_oor1
);

    localparam logic [SEL_W:0] c_NREGS = NREGS[SEL_W:0];

    logic [WIDTH-1:0]       r_regs [NREGS];
    logic [NREGS*WIDTH-1:0] w_regs_flat;
    logic                   w_we;

    // Writes to a missing register, or to a hardwired zero register, are dropped
    assign w_we = wr_en && ({1'b0, wr_sel} < c_NREGS) && !(ZERO_REG && (wr_sel == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_we && (wr_sel == SEL_W'(i))) begin
                    r_regs[i] <= wr_data;
                end
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign w_regs_flat[g*WIDTH +: WIDTH] = r_regs[g];
    end

    regfile_read_port #(
        .WIDTH    (WIDTH),
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_rd0 (
        .clk        (clk),
        .rst        (rst),
        .i_regs     (w_regs_flat),
        .i_wr_en    (wr_en),
        .i_wr_sel   (wr_sel),
        .i_wr_data  (wr_data),
        .i_rd_en    (rd_en0),
        .i_rd_sel   (rd_sel0),
        .o_rd_data  (rd_data0),
        .o_rd_valid (rd_valid0),
        .o_rd_oor   (rd_oor0)
    );

    regfile_read_port #(
        .WIDTH    (WIDTH),
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_rd1 (
        .clk        (clk),
        .rst        (rst),
        .i_regs     (w_regs_flat),
        .i_wr_en    (wr_en),
        .i_wr_sel   (wr_sel),
        .i_wr_data  (wr_data),
        .i_rd_en    (rd_en1),
        .i_rd_sel   (rd_sel1),
        .o_rd_data  (rd_data1),
        .o_rd_valid (rd_valid1),
        .o_rd_oor   (rd_oor1)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_2r1w
// Description : Drives a default 8x16 instance and a 6x32 zero-register
//               instance from one stimulus stream, checked against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_sel = '0;
    logic [31:0] wr_data = '0;
    logic        rd_en0 = 1'b0;
    logic        rd_en1 = 1'b0;
    logic [2:0]  rd_sel0 = '0;
    logic [2:0]  rd_sel1 = '0;

    logic [15:0] a_d0, a_d1;
    logic        a_v0, a_v1, a_o0, a_o1;
    logic [31:0] b_d0, b_d1;
    logic        b_v0, b_v1, b_o0, b_o1;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    regfile_2r1w u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data[15:0]),
        .rd_en0(rd_en0), .rd_sel0(rd_sel0), .rd_en1(rd_en1), .rd_sel1(rd_sel1),
        .rd_data0(a_d0), .rd_data1(a_d1), .rd_valid0(a_v0), .rd_valid1(a_v1),
        .rd_oor0(a_o0), .rd_oor1(a_o1)
    );

    regfile_2r1w #(.WIDTH(32), .NREGS(6), .ZERO_REG(1'b1)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_en0(rd_en0), .rd_sel0(rd_sel0), .rd_en1(rd_en1), .rd_sel1(rd_sel1),
        .rd_data0(b_d0), .rd_data1(b_d1), .rd_valid0(b_v0), .rd_valid1(b_v1),
        .rd_oor0(b_o0), .rd_oor1(b_o1)
    );

    // Reference model: plain arrays, expected outputs from the read rules
    logic [15:0] mA [8];
    logic [31:0] mB [6];
    logic [15:0] eAd0, eAd1;
    logic [31:0] eBd0, eBd1;
    logic        eAv0, eAv1, eAo0, eAo1, eBv0, eBv1, eBo0, eBo1;

    function automatic logic [15:0] val_a(input logic [2:0] s);
        if (wr_en && wr_sel == s) return wr_data[15:0];
        return mA[int'(s)];
    endfunction

    function automatic logic [31:0] val_b(input logic [2:0] s);
        if (int'(s) >= 6) return 32'h0;
        if (s == 3'd0) return 32'h0;
        if (wr_en && wr_sel == s) return wr_data;
        return mB[int'(s)];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mA[i] <= '0;
            for (int i = 0; i < 6; i++) mB[i] <= '0;
            eAd0 <= '0; eAd1 <= '0; eBd0 <= '0; eBd1 <= '0;
            eAv0 <= 1'b0; eAv1 <= 1'b0; eAo0 <= 1'b0; eAo1 <= 1'b0;
            eBv0 <= 1'b0; eBv1 <= 1'b0; eBo0 <= 1'b0; eBo1 <= 1'b0;
        end else begin
            if (wr_en) mA[int'(wr_sel)] <= wr_data[15:0];
            if (wr_en && int'(wr_sel) < 6 && wr_sel != 3'd0) mB[int'(wr_sel)] <= wr_data;
            eAv0 <= rd_en0; eBv0 <= rd_en0;
            eAv1 <= rd_en1; eBv1 <= rd_en1;
            if (rd_en0) begin
                eAd0 <= val_a(rd_sel0); eAo0 <= (int'(rd_sel0) >= 8);
                eBd0 <= val_b(rd_sel0); eBo0 <= (int'(rd_sel0) >= 6);
            end
            if (rd_en1) begin
                eAd1 <= val_a(rd_sel1); eAo1 <= (int'(rd_sel1) >= 8);
                eBd1 <= val_b(rd_sel1); eBo1 <= (int'(rd_sel1) >= 6);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("A.data0", 32'(a_d0), 32'(eAd0));
            chk("A.data1", 32'(a_d1), 32'(eAd1));
            chk("A.valid0", 32'(a_v0), 32'(eAv0));
            chk("A.valid1", 32'(a_v1), 32'(eAv1));
            chk("A.oor0", 32'(a_o0), 32'(eAo0));
            chk("A.oor1", 32'(a_o1), 32'(eAo1));
            chk("B.data0", b_d0, eBd0);
            chk("B.data1", b_d1, eBd1);
            chk("B.valid0", 32'(b_v0), 32'(eBv0));
            chk("B.valid1", 32'(b_v1), 32'(eBv1));
            chk("B.oor0", 32'(b_o0), 32'(eBo0));
            chk("B.oor1", 32'(b_o1), 32'(eBo1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en0 = 1'b0; rd_en1 = 1'b0;
    endtask

    task automatic wr(input logic [2:0] s, input logic [31:0] d);
        wr_en = 1'b1; wr_sel = s; wr_data = d;
    endtask

    initial begin
        #1 rst = 1'b1;
        chk_en = 1'b1;
        tick(); tick();
        chk("reset.data0", 32'(a_d0), 32'h0);
        chk("reset.valid0", 32'(a_v0), 32'h0);
        rst = 1'b0;

        // Read everything after reset, with a gap so valid must drop
        for (int i = 0; i < 8; i++) begin
            rd_en0 = 1'b1; rd_en1 = 1'b1; rd_sel0 = 3'(i); rd_sel1 = 3'(i);
            tick();
            chk("rst_read.data0", 32'(a_d0), 32'h0);
            chk("rst_read.valid0", 32'(a_v0), 32'h1);
            chk("rst_read.oor0", 32'(a_o0), 32'h0);
            idle();
            tick();
            chk("rst_read.valid_drop", 32'(a_v0), 32'h0);
        end

        for (int i = 0; i < 8; i++) begin
            wr(3'(i), 32'hA000 + 32'(i));
            tick();
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            rd_en0 = 1'b1; rd_en1 = 1'b1; rd_sel0 = 3'(i); rd_sel1 = 3'(7 - i);
            tick();
            chk("wr_read.data0", 32'(a_d0), 32'hA000 + 32'(i));
            chk("wr_read.data1", 32'(a_d1), 32'hA007 - 32'(i));
            chk("wr_read.valid_b2b", 32'(a_v0), 32'h1);
        end
        idle();

        wr(3'd3, 32'h1111); tick();
        wr(3'd3, 32'h2222); rd_en0 = 1'b1; rd_sel0 = 3'd3; tick();
        chk("bypass.data0", 32'(a_d0), 32'h2222);
        chk("bypass.B.data0", b_d0, 32'h2222);
        idle();

        wr(3'd5, 32'h5555); tick();
        wr_en = 1'b0; rd_en0 = 1'b1; rd_sel0 = 3'd5; tick();
        chk("stall.capture", 32'(a_d0), 32'h5555);
        rd_en0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr(3'd5, 32'h6666); tick();
            chk("stall.hold_data", 32'(a_d0), 32'h5555);
            chk("stall.hold_valid", 32'(a_v0), 32'h0);
        end
        idle(); rd_en0 = 1'b1; tick();
        chk("stall.recapture", 32'(a_d0), 32'h6666);
        idle();

        wr(3'd0, 32'hFFFF_FFFF); tick();
        wr_en = 1'b0; rd_en0 = 1'b1; rd_sel0 = 3'd0; tick();
        chk("zero.B.data0", b_d0, 32'h0);
        chk("zero.A.data0", 32'(a_d0), 32'hFFFF);
        idle();

        rd_en0 = 1'b1; rd_sel0 = 3'd6; rd_en1 = 1'b1; rd_sel1 = 3'd7; tick();
        chk("oor.B.data0", b_d0, 32'h0);
        chk("oor.B.oor0", 32'(b_o0), 32'h1);
        chk("oor.B.oor1", 32'(b_o1), 32'h1);
        chk("oor.A.oor0", 32'(a_o0), 32'h0);
        chk("oor.A.data0", 32'(a_d0), 32'hA006);
        idle();

        wr(3'd7, 32'h1234_5678); tick();
        wr_en = 1'b0; rd_en0 = 1'b1; rd_sel0 = 3'd5; rd_en1 = 1'b1; rd_sel1 = 3'd4; tick();
        chk("sel7.B.reg5", b_d0, 32'h6666);
        chk("sel7.B.reg4", b_d1, 32'hA004);
        idle();

        for (int n = 0; n < 1500; n++) begin
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_sel  = 3'($urandom_range(0, 7));
            wr_data = $urandom;
            rd_en0  = ($urandom_range(0, 3) != 0);
            rd_en1  = ($urandom_range(0, 3) != 0);
            rd_sel0 = 3'($urandom_range(0, 7));
            rd_sel1 = ($urandom_range(0, 3) == 0) ? wr_sel : 3'($urandom_range(0, 7));
            tick();
        end
        idle();

        wr(3'd2, 32'hBEEF); tick();
        wr_en = 1'b0; rd_en0 = 1'b1; rd_sel0 = 3'd2; tick();
        chk("async.pre_data0", 32'(a_d0), 32'hBEEF);
        chk("async.pre_valid0", 32'(a_v0), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async.data0", 32'(a_d0), 32'h0);
        chk("async.valid0", 32'(a_v0), 32'h0);
        idle();
        tick();
        rst = 1'b0;
        rd_en0 = 1'b1; rd_sel0 = 3'd2; tick();
        chk("async.regs_cleared", 32'(a_d0), 32'h0);
        idle();
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
